// File: rtl/event_stretcher.sv
// rtl/event_stretcher.sv - stretches single-cycle events into fixed on/off lamp flashes
//
// Turns one-cycle event pulses into lamp/buzzer flashes that a person can see or hear.
// Each flash is ON_CYCLES cycles lit, followed by an OFF_CYCLES dark gap.
//
// Optional feature: define STRETCH_QUEUE_EN to enable the replay queue.
//   With the queue, events that arrive during a flash are counted and replayed back-to-back.
//   Without the queue, those events are discarded and pending stays at 0.
//
// Ports:
//   clk_fpga  in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   event_in  in   event pulse; a level held N cycles counts as N events
//   lamp      out  registered flash output
//   busy      out  high while a flash or its dark gap is in progress
//   pending   out  queued flashes not yet started
//   dropped   out  one-cycle pulse when an event is discarded
module event_stretcher #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int ON_MS       = 200,
    parameter int OFF_MS      = 100,
    parameter int MAX_PENDING = 7,
    localparam int ON_CYCLES  = CLK_HZ / 1000 * ON_MS,
    localparam int OFF_CYCLES = CLK_HZ / 1000 * OFF_MS,
    localparam int PW         = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk_fpga,
    input  logic          reset,
    input  logic          event_in,
    output logic          lamp,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          dropped
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    logic [PW-1:0]   pend_d;
    logic            lamp_d;
    logic            busy_d;
    logic            drop_d;
    logic            pend_nz;
    logic            phase_end;
    logic            ev_extra;

    assign pend_nz   = (pending != '0);
    assign phase_end = (cnt == '0);
    // Any event that does not itself launch a flash from an empty IDLE must be queued or dropped.
    assign ev_extra  = event_in && !((state == S_IDLE) && !pend_nz);

    // State register plus registered outputs; every output comes from a flop.
    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pending <= '0;
            lamp    <= 1'b0;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            pending <= pend_d;
            lamp    <= lamp_d;
            busy    <= busy_d;
            dropped <= drop_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (event_in || pend_nz) begin
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (phase_end) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    state_d = pend_nz ? S_ON : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef STRETCH_QUEUE_EN
    logic consume;
    // A queued flash starts either from IDLE (an event landed on the GAP-end edge)
    // or directly at the end of the current gap.
    assign consume = pend_nz && ((state == S_IDLE) || ((state == S_GAP) && phase_end));
`endif

    // Output / datapath logic
    always_comb begin
        cnt_d  = cnt;
        pend_d = pending;
        drop_d = 1'b0;

        // The counter is reloaded on entry to each phase and counts down to 0.
        // Zero on the last edge of the phase, so a phase lasts exactly (load + 1) edges.
        if ((state_d == S_ON) && (state != S_ON)) begin
            cnt_d = CW'(ON_CYCLES - 1);
        end else if ((state_d == S_GAP) && (state != S_GAP)) begin
            cnt_d = CW'(OFF_CYCLES - 1);
        end else if ((state != S_IDLE) && !phase_end) begin
            cnt_d = cnt - CW'(1);
        end

`ifdef STRETCH_QUEUE_EN
        // A new event and a consumed entry on the same edge cancel out.
        if (consume && !ev_extra) begin
            pend_d = pending - PW'(1);
        end else if (!consume && ev_extra) begin
            if (pending != PW'(MAX_PENDING)) begin
                pend_d = pending + PW'(1);
            end else begin
                drop_d = 1'b1;
            end
        end
`else
        pend_d = '0;
        drop_d = ev_extra;
`endif

        lamp_d = (state_d == S_ON);
        busy_d = (state_d != S_IDLE);
    end

endmodule
